// File: rtl/simon_pkg.sv
// Shared types and defaults for the Simon sequence engine.
// Colour encoding, FSM states and width helpers.
package simon_pkg;

  typedef logic [1:0] color_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADD,
    ST_SHOW_ON,
    ST_SHOW_OFF,
    ST_INPUT,
    ST_WIN,
    ST_FAIL
  } state_t;

  localparam int MAX_LEN_DEF    = 16;
  localparam int SHOW_TICKS_DEF = 4;
  localparam int GAP_TICKS_DEF  = 2;

  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/simon_sequence_engine_if.sv
// Game-side bundle of the Simon sequence engine.
// master = stimulus/player side, slave = engine.
interface simon_sequence_engine_if #(
  parameter int MAX_LEN = simon_pkg::MAX_LEN_DEF
);
  import simon_pkg::*;

  localparam int LW = $clog2(MAX_LEN + 1);

  color_t          rnd;
  logic            start;
  logic            player_valid;
  color_t          player_color;
  logic            show_valid;
  color_t          show_color;
  logic            awaiting_in;
  logic [LW-1:0]   level;
  logic            game_over;
  logic            win;

  modport master (
    output rnd,
    output start,
    output player_valid,
    output player_color,
    input  show_valid,
    input  show_color,
    input  awaiting_in,
    input  level,
    input  game_over,
    input  win
  );

  modport slave (
    input  rnd,
    input  start,
    input  player_valid,
    input  player_color,
    output show_valid,
    output show_color,
    output awaiting_in,
    output level,
    output game_over,
    output win
  );

endinterface

// File: rtl/step_timer.sv
// Loadable down-counter; done while the count sits at zero.
// Shared by the lit and dark phases of playback.
module step_timer #(
  parameter int W = 2
) (
  input  logic         slow_clk1,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge slow_clk1 or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/simon_sequence_engine.sv
// Simon game core: grows a colour sequence, plays it back,
// then checks the player's entries against it.
module simon_sequence_engine
  import simon_pkg::*;
#(
  parameter int MAX_LEN    = MAX_LEN_DEF,
  parameter int SHOW_TICKS = SHOW_TICKS_DEF,
  parameter int GAP_TICKS  = GAP_TICKS_DEF
) (
  input  logic                     slow_clk1,
  input  logic                     rst_n,
  simon_sequence_engine_if.slave   bus
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int IW = clog2_min1(MAX_LEN);
  localparam int TMAX =
    (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
  localparam int TW = clog2_min1(TMAX);

  state_t        state_q;
  state_t        state_d;
  logic [LW-1:0] len_q;
  logic [LW-1:0] len_d;
  logic [IW-1:0] idx_q;
  logic [IW-1:0] idx_d;
  color_t        mem_q [MAX_LEN];

  logic          t_load;
  logic [TW-1:0] t_val;
  logic          t_done;
  logic          add_en;
  logic          hit;
  logic          last;
  logic          full;

  step_timer #(.W(TW)) u_timer (
    .slow_clk1 (slow_clk1),
    .rst_n     (rst_n),
    .load      (t_load),
    .load_val  (t_val),
    .done      (t_done)
  );

  assign hit  = (bus.player_color == mem_q[idx_q]);
  assign last = ((LW'(idx_q) + LW'(1)) == len_q);
  assign full = (len_q == LW'(MAX_LEN));

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    t_load  = 1'b0;
    t_val   = TW'(SHOW_TICKS - 1);
    add_en  = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_WIN, ST_FAIL: begin
        if (bus.start) begin
          len_d   = '0;
          idx_d   = '0;
          state_d = ST_ADD;
        end
      end
      ST_ADD: begin
        add_en  = 1'b1;
        len_d   = len_q + LW'(1);
        idx_d   = '0;
        t_load  = 1'b1;
        state_d = ST_SHOW_ON;
      end
      ST_SHOW_ON: begin
        if (t_done) begin
          t_load  = 1'b1;
          t_val   = TW'(GAP_TICKS - 1);
          state_d = ST_SHOW_OFF;
        end
      end
      ST_SHOW_OFF: begin
        if (t_done) begin
          if (last) begin
            idx_d   = '0;
            state_d = ST_INPUT;
          end else begin
            idx_d   = idx_q + IW'(1);
            t_load  = 1'b1;
            state_d = ST_SHOW_ON;
          end
        end
      end
      ST_INPUT: begin
        if (bus.player_valid) begin
          unique case (1'b1)
            !hit:
              state_d = ST_FAIL;
            hit && !last:
              idx_d = idx_q + IW'(1);
            hit && last && full:
              state_d = ST_WIN;
            hit && last && !full:
              state_d = ST_ADD;
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge slow_clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
    end
  end

  // ADD only runs while len < MAX_LEN, so the low bits address mem
  always_ff @(posedge slow_clk1 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        mem_q[i] <= '0;
      end
    end else if (add_en) begin
      mem_q[len_q[IW-1:0]] <= bus.rnd;
    end
  end

  assign bus.show_valid  = (state_q == ST_SHOW_ON);
  assign bus.show_color  =
    (state_q == ST_SHOW_ON) ? mem_q[idx_q] : '0;
  assign bus.awaiting_in = (state_q == ST_INPUT);
  assign bus.level       = len_q;
  assign bus.game_over   = (state_q == ST_FAIL);
  assign bus.win         = (state_q == ST_WIN);

endmodule

// File: tb/tb_simon_sequence_engine.sv
// Randomized bench for simon_sequence_engine (16- and 2-step builds)
// against a round-timeline model of the game.
module tb_simon_sequence_engine;
  import simon_pkg::*;

  localparam int S = 4;
  localparam int G = 2;
  localparam int P = S + G;

  logic clk;
  logic rst_n;

  simon_sequence_engine_if #(.MAX_LEN(16)) i16 ();
  simon_sequence_engine_if #(.MAX_LEN(2))  i2 ();

  simon_sequence_engine #(.MAX_LEN(16)) dut16 (
    .slow_clk1 (clk),
    .rst_n     (rst_n),
    .bus       (i16)
  );

  simon_sequence_engine #(.MAX_LEN(2)) dut2 (
    .slow_clk1 (clk),
    .rst_n     (rst_n),
    .bus       (i2)
  );

  logic   start_v [2];
  logic   pv_v    [2];
  color_t rnd_v   [2];
  color_t pc_v    [2];
  bit     perfect [2];

  assign i16.start        = start_v[0];
  assign i16.player_valid = pv_v[0];
  assign i16.rnd          = rnd_v[0];
  assign i16.player_color = pc_v[0];
  assign i2.start         = start_v[1];
  assign i2.player_valid  = pv_v[1];
  assign i2.rnd           = rnd_v[1];
  assign i2.player_color  = pc_v[1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- behavioural model ----------------
  typedef enum {M_IDLE, M_ROUND, M_INPUT, M_WIN, M_FAIL} mmode_t;
  mmode_t m_mode [2];
  int     m_t    [2];
  int     m_len  [2];
  int     m_ent  [2];
  color_t m_seq  [2][16];

  function automatic int maxl(int k);
    return (k == 0) ? 16 : 2;
  endfunction

  task automatic m_step(int k);
    case (m_mode[k])
      M_IDLE, M_WIN, M_FAIL:
        if (start_v[k]) begin
          m_len[k]  = 0;
          m_t[k]    = 0;
          m_mode[k] = M_ROUND;
        end
      M_ROUND: begin
        if (m_t[k] == 0) begin
          m_seq[k][m_len[k]] = rnd_v[k];
          m_len[k]++;
        end
        m_t[k]++;
        if (m_t[k] == 1 + m_len[k] * P) begin
          m_mode[k] = M_INPUT;
          m_ent[k]  = 0;
        end
      end
      M_INPUT:
        if (pv_v[k]) begin
          if (pc_v[k] == m_seq[k][m_ent[k]]) begin
            m_ent[k]++;
            if (m_ent[k] == m_len[k]) begin
              if (m_len[k] == maxl(k)) m_mode[k] = M_WIN;
              else begin
                m_mode[k] = M_ROUND;
                m_t[k]    = 0;
              end
            end
          end else begin
            m_mode[k] = M_FAIL;
          end
        end
      default: ;
    endcase
  endtask

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_mode[k] = M_IDLE;
        m_t[k]    = 0;
        m_len[k]  = 0;
        m_ent[k]  = 0;
      end else begin
        m_step(k);
      end
    end
  end

  function automatic bit e_sv(int k);
    return m_mode[k] == M_ROUND && m_t[k] >= 1 &&
           ((m_t[k] - 1) % P) < S;
  endfunction

  function automatic color_t e_col(int k);
    if (!e_sv(k)) return 2'b00;
    return m_seq[k][(m_t[k] - 1) / P];
  endfunction

  // ---------------- DUT readback ----------------
  function automatic logic [31:0] a_sv(int k);
    return (k == 0) ? 32'(i16.show_valid) : 32'(i2.show_valid);
  endfunction
  function automatic logic [31:0] a_col(int k);
    return (k == 0) ? 32'(i16.show_color) : 32'(i2.show_color);
  endfunction
  function automatic logic [31:0] a_aw(int k);
    return (k == 0) ? 32'(i16.awaiting_in) : 32'(i2.awaiting_in);
  endfunction
  function automatic logic [31:0] a_lvl(int k);
    return (k == 0) ? 32'(i16.level) : 32'(i2.level);
  endfunction
  function automatic logic [31:0] a_go(int k);
    return (k == 0) ? 32'(i16.game_over) : 32'(i2.game_over);
  endfunction
  function automatic logic [31:0] a_win(int k);
    return (k == 0) ? 32'(i16.win) : 32'(i2.win);
  endfunction

  task automatic chk(string nm, int k,
                     logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d] @%0t: got %0h, required %0h",
               nm, k, $time, act, exp);
    end
  endtask

  // every-cycle compare against the model
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk("show_valid", k, a_sv(k), 32'(e_sv(k)));
      chk("show_color", k, a_col(k), 32'(e_col(k)));
      chk("awaiting_in", k, a_aw(k), 32'(m_mode[k] == M_INPUT));
      chk("level", k, a_lvl(k), 32'(m_len[k]));
      chk("game_over", k, a_go(k), 32'(m_mode[k] == M_FAIL));
      chk("win", k, a_win(k), 32'(m_mode[k] == M_WIN));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(int k, color_t c);
    pv_v[k] = 1'b1;
    pc_v[k] = c;
    step();
    pv_v[k] = 1'b0;
  endtask

  task automatic pulse_start(int k);
    start_v[k] = 1'b1;
    step();
    start_v[k] = 1'b0;
  endtask

  task automatic wait_input(int k);
    int n;
    n = 0;
    while (a_aw(k) !== 32'd1 && n < 400) begin
      step();
      n++;
    end
    n_cmp++;
    if (a_aw(k) !== 32'd1) begin
      n_bad++;
      $display("FAIL wait_input[%0d]: awaiting_in=0 after %0d cycles, required 1",
               k, n);
    end
  endtask

  task automatic rand_drive(int k);
    rnd_v[k]   = color_t'($urandom);
    start_v[k] = 1'b0;
    pv_v[k]    = 1'b0;
    if (m_mode[k] inside {M_IDLE, M_WIN, M_FAIL}) begin
      if ($urandom_range(0, 3) == 0) begin
        start_v[k] = 1'b1;
        perfect[k] = bit'($urandom_range(0, 1));
      end
    end else if ($urandom_range(0, 31) == 0) begin
      start_v[k] = 1'b1;
    end
    if (m_mode[k] == M_INPUT) begin
      if ($urandom_range(0, 1) == 1) begin
        pv_v[k] = 1'b1;
        if (perfect[k] || $urandom_range(0, 19) != 0)
          pc_v[k] = m_seq[k][m_ent[k]];
        else
          pc_v[k] = color_t'($urandom);
      end
    end else if ($urandom_range(0, 7) == 0) begin
      pv_v[k] = 1'b1;
      pc_v[k] = color_t'($urandom);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      start_v[k] = 1'b0;
      pv_v[k]    = 1'b0;
      rnd_v[k]   = 2'b00;
      pc_v[k]    = 2'b00;
      perfect[k] = 1'b0;
    end
    repeat (3) step();
    rst_n = 1'b1;
    repeat (10) step();
    chk("idle_show_valid", 0, a_sv(0), 0);
    chk("idle_awaiting", 0, a_aw(0), 0);
    chk("idle_level", 0, a_lvl(0), 0);
    chk("idle_go_win", 0, a_go(0) | a_win(0), 0);

    // round 1 with rnd=10, one stray press while lit
    rnd_v[0] = 2'b10;
    pulse_start(0);
    chk("add_level", 0, a_lvl(0), 0);
    chk("add_dark", 0, a_sv(0), 0);
    step();
    for (int i = 0; i < 4; i++) begin
      chk("r1_lit", 0, a_sv(0), 1);
      chk("r1_color", 0, a_col(0), 32'h2);
      pv_v[0] = (i == 1);
      pc_v[0] = 2'b10;
      step();
    end
    pv_v[0] = 1'b0;
    chk("r1_gap0", 0, a_sv(0), 0);
    step();
    chk("r1_gap1", 0, a_sv(0) | a_aw(0), 0);
    step();
    chk("r1_input", 0, a_aw(0), 1);
    chk("r1_level", 0, a_lvl(0), 1);

    // round 2 with rnd=01, then both entries correct
    rnd_v[0] = 2'b01;
    press(0, 2'b10);
    wait_input(0);
    chk("r2_level", 0, a_lvl(0), 2);
    press(0, 2'b10);
    press(0, 2'b01);
    chk("r3_add_level", 0, a_lvl(0), 2);
    step();
    chk("r3_level", 0, a_lvl(0), 3);

    // start ignored in INPUT, then a wrong entry fails round 3
    wait_input(0);
    pulse_start(0);
    chk("start_ign", 0, a_aw(0), 1);
    press(0, 2'b11);
    chk("fail_go", 0, a_go(0), 1);
    chk("fail_lvl3", 0, a_lvl(0), 3);

    // fresh game, mem[0]=10, press 11
    rnd_v[0] = 2'b10;
    pulse_start(0);
    wait_input(0);
    press(0, 2'b11);
    chk("fail1_go", 0, a_go(0), 1);
    chk("fail1_lvl", 0, a_lvl(0), 1);
    chk("fail1_aw", 0, a_aw(0), 0);
    pulse_start(0);
    step();
    chk("restart_lvl", 0, a_lvl(0), 1);
    chk("restart_lit", 0, a_sv(0), 1);
    step();

    // asynchronous reset mid playback
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sv", 0, a_sv(0), 0);
    chk("arst_lvl", 0, a_lvl(0), 0);
    chk("arst_go", 0, a_go(0) | a_win(0) | a_aw(0), 0);
    step();
    rst_n = 1'b1;
    step();

    // 2-step build: two correct rounds then WIN
    rnd_v[1] = color_t'($urandom);
    pulse_start(1);
    rnd_v[1] = color_t'($urandom);
    wait_input(1);
    press(1, m_seq[1][0]);
    wait_input(1);
    chk("w2_level", 1, a_lvl(1), 2);
    press(1, m_seq[1][0]);
    press(1, m_seq[1][1]);
    chk("win", 1, a_win(1), 1);
    chk("win_lvl", 1, a_lvl(1), 2);
    press(1, m_seq[1][0]);
    repeat (3) step();
    chk("win_hold", 1, a_win(1), 1);
    chk("win_no_add", 1, a_sv(1) | a_aw(1), 0);

    // randomized play on both builds
    for (int c = 0; c < 9000; c++) begin
      for (int k = 0; k < 2; k++) rand_drive(k);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
